apb_master_ctrl: RTL and testbench

- APB master and sequencer for the two-slave APB subsystem. Each slave has a 64-entry x 8-bit memory.
- Accepts single read/write commands from a host over a valid/ready interface.
- Decodes the target slave and drives the APB SETUP/ACCESS protocol.
- Waits on the selected slave's PREADY, then returns read data and an error flag on a one-cycle response strobe.

---
 rtl/apb_master_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB master/sequencer for a two-slave subsystem: host valid/ready command in, one-cycle response strobe out.
// Optional ACCESS-phase timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl #(
    parameter int DATA_W         = 8,
    parameter int MEM_DEPTH      = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [8:0]        req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [7:0]        PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY1,
    input  logic              PREADY2
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                psel1_q, psel1_d;
    logic                psel2_q, psel2_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [7:0]          paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                sel2_q, sel2_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    // Only the addressed slave's handshake matters; the other slave's lines are ignored.
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    assign sel_ready = sel2_q ? PREADY2 : PREADY1;
    assign sel_rdata = sel2_q ? PRDATA2 : PRDATA1;

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        psel1_d     = psel1_q;
        psel2_d     = psel2_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        sel2_d      = sel2_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    if ({1'b0, req_addr[7:0]} >= DEPTH_LIM) begin
                        // Out-of-range address: answer with an error, never touch the bus.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d  = SETUP;
                        sel2_d   = req_addr[8];
                        psel1_d  = ~req_addr[8];
                        psel2_d  = req_addr[8];
                        paddr_d  = req_addr[7:0];
                        pwrite_d = req_write;
                        pwdata_d = req_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_d     = RESP;
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
                end else begin
`ifdef APB_MASTER_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d     = RESP;
                        psel1_d     = 1'b0;
                        psel2_d     = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
`endif
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            sel2_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            sel2_q      <= sel2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign PSEL1     = psel1_q;
    assign PSEL2     = psel2_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: two behavioural APB slaves with programmable wait states,
// directed scenarios followed by random commands checked against an address-indexed memory model.
module tb_apb_master_ctrl;

    localparam int DATA_W = 8;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [8:0]        req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0]        PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA1, PRDATA2;
    logic              PREADY1, PREADY2;

    int passCount  = 0;
    int totalCount = 0;

    bit   [7:0] modelMem [2][64];
    logic [7:0] mem1 [64];
    logic [7:0] mem2 [64];
    int         acc1 = 0;
    int         acc2 = 0;
    int         waitCfg = 0;
    bit         noise1 = 0;
    bit         noise2 = 0;
    bit         loadMem = 1;

    apb_master_ctrl dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
    );

    always #5 PCLK = ~PCLK;

    // Slaves answer after waitCfg ACCESS cycles; when not selected their PREADY is random noise.
    assign PREADY1 = (PSEL1 && PENABLE) ? (acc1 >= waitCfg) : noise1;
    assign PREADY2 = (PSEL2 && PENABLE) ? (acc2 >= waitCfg) : noise2;
    assign PRDATA1 = mem1[PADDR[5:0]];
    assign PRDATA2 = mem2[PADDR[5:0]];

    always @(negedge PCLK) begin
        noise1 <= 1'($urandom);
        noise2 <= 1'($urandom);
    end

    always @(posedge PCLK) begin
        if (loadMem) begin
            for (int i = 0; i < 64; i++) begin
                mem1[i] <= modelMem[0][i];
                mem2[i] <= modelMem[1][i];
            end
        end else begin
            if (PSEL1 && PENABLE) begin
                if (PREADY1) begin
                    if (PWRITE) mem1[PADDR[5:0]] <= PWDATA;
                    acc1 <= 0;
                end else acc1 <= acc1 + 1;
            end else acc1 <= 0;
            if (PSEL2 && PENABLE) begin
                if (PREADY2) begin
                    if (PWRITE) mem2[PADDR[5:0]] <= PWDATA;
                    acc2 <= 0;
                end else acc2 <= acc2 + 1;
            end else acc2 <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".psel1"}, PSEL1, 0);
        checkOutput({tag, ".psel2"}, PSEL2, 0);
        checkOutput({tag, ".penable"}, PENABLE, 0);
        checkOutput({tag, ".pwrite"}, PWRITE, 0);
        checkOutput({tag, ".paddr"}, PADDR, 0);
        checkOutput({tag, ".pwdata"}, PWDATA, 0);
        checkOutput({tag, ".rspvalid"}, rsp_valid, 0);
        checkOutput({tag, ".rdata"}, rsp_rdata, 0);
        checkOutput({tag, ".err"}, rsp_err, 0);
        checkOutput({tag, ".ready"}, req_ready, 1);
    endtask

    // Waits (bounded) for req_ready, then presents one command for one clock edge.
    task automatic issueCommand(input string tag, input bit wr, input bit [8:0] addr, input bit [7:0] wd);
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge PCLK);
            guard++;
        end
        checkOutput({tag, ".acceptReady"}, req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
    endtask

    // Full transaction: expected latency and data come from the memory model, not from the DUT.
    task automatic applyStimulus(input string tag, input bit wr, input bit [8:0] addr,
                                 input bit [7:0] wd, input int waits);
        bit       isErr = (addr[7:0] >= 8'd64);
        bit       sel2  = addr[8];
        int       lat   = isErr ? 1 : 3 + waits;
        bit [7:0] expR  = (!wr && !isErr) ? modelMem[sel2][addr[5:0]] : 8'h00;
        waitCfg = waits;
        issueCommand(tag, wr, addr, wd);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge PCLK);
            if (k == 1) begin
                checkOutput($sformatf("%s.c1.psel1", tag), PSEL1, !isErr && !sel2);
                checkOutput($sformatf("%s.c1.psel2", tag), PSEL2, !isErr && sel2);
                checkOutput($sformatf("%s.c1.penable", tag), PENABLE, 0);
            end
            if (k >= 2 && k < lat) begin
                checkOutput($sformatf("%s.c%0d.penable", tag, k), PENABLE, 1);
                checkOutput($sformatf("%s.c%0d.paddr", tag, k), PADDR, addr[7:0]);
                checkOutput($sformatf("%s.c%0d.pwrite", tag, k), PWRITE, wr);
                if (wr) checkOutput($sformatf("%s.c%0d.pwdata", tag, k), PWDATA, wd);
            end
            checkOutput($sformatf("%s.c%0d.rspvalid", tag, k), rsp_valid, k == lat);
        end
        checkOutput({tag, ".rdata"}, rsp_rdata, expR);
        checkOutput({tag, ".err"}, rsp_err, isErr);
        checkOutput({tag, ".respPsel"}, PSEL1 | PSEL2 | PENABLE, 0);
        @(negedge PCLK);
        checkOutput({tag, ".after.rspvalid"}, rsp_valid, 0);
        checkOutput({tag, ".after.ready"}, req_ready, 1);
        checkOutput({tag, ".after.rdataHeld"}, rsp_rdata, expR);
        if (wr && !isErr) modelMem[sel2][addr[5:0]] = wd;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit [7:0] keep63;
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            modelMem[0][i] = 8'($urandom);
            modelMem[1][i] = 8'($urandom);
        end
        loadMem = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET  = 1'b0;
        loadMem = 1'b0;
        checkAllZero("reset");

        applyStimulus("wrS1", 1'b1, 9'h005, 8'hA5, 0);
        checkOutput("mem1[5]", mem1[5], 8'hA5);
        applyStimulus("rdS1", 1'b0, 9'h005, 8'h00, 0);

        keep63 = modelMem[0][63];
        applyStimulus("wrS2", 1'b1, 9'h13F, 8'h3C, 0);
        applyStimulus("rdS2", 1'b0, 9'h13F, 8'h00, 0);
        checkOutput("mem1[63]kept", mem1[63], keep63);
        checkOutput("mem2[63]", mem2[63], 8'h3C);

        applyStimulus("decErrWr", 1'b1, 9'h040, 8'h77, 0);
        applyStimulus("decErrRd", 1'b0, 9'h1FF, 8'h00, 0);

        applyStimulus("waitWr", 1'b1, 9'h120, 8'h5A, 3);
        applyStimulus("waitRd", 1'b0, 9'h120, 8'h00, 3);

        // Stalled slave1 read interrupted by reset: no response, bus returns to zero.
        waitCfg = 1000;
        issueCommand("midRst", 1'b0, 9'h00A, 8'h00);
        repeat (2) @(negedge PCLK);
        checkOutput("midRst.psel1", PSEL1, 1);
        checkOutput("midRst.penable", PENABLE, 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        checkAllZero("midRst.after");
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            checkOutput($sformatf("midRst.noRsp%0d", k), rsp_valid, 0);
        end
        applyStimulus("postRst", 1'b0, 9'h00A, 8'h00, 1);

        waitCfg = 1000;
        issueCommand("stuck", 1'b0, 9'h011, 8'h00);
`ifdef APB_MASTER_TIMEOUT_EN
        for (int k = 2; k <= 18; k++) begin
            @(negedge PCLK);
            if (k < 18) begin
                checkOutput($sformatf("tmo.c%0d.psel1", k), PSEL1, 1);
                checkOutput($sformatf("tmo.c%0d.rspvalid", k), rsp_valid, 0);
            end
        end
        checkOutput("tmo.rspvalid", rsp_valid, 1);
        checkOutput("tmo.err", rsp_err, 1);
        checkOutput("tmo.rdata", rsp_rdata, 0);
        checkOutput("tmo.psel1", PSEL1, 0);
        checkOutput("tmo.penable", PENABLE, 0);
        @(negedge PCLK);
`else
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            if (k % 10 == 9) begin
                checkOutput($sformatf("stuck.%0d.psel1", k), PSEL1, 1);
                checkOutput($sformatf("stuck.%0d.penable", k), PENABLE, 1);
                checkOutput($sformatf("stuck.%0d.rspvalid", k), rsp_valid, 0);
            end
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        checkAllZero("stuck.rst");
`endif

        for (int n = 0; n < 24; n++) begin
            bit       wr;
            bit [8:0] addr;
            bit [7:0] wd;
            wr   = 1'($urandom);
            wd   = 8'($urandom);
            addr[8] = 1'($urandom);
            if ($urandom_range(0, 7) == 0) addr[7:0] = 8'($urandom_range(64, 255));
            else addr[7:0] = 8'($urandom_range(0, 63));
            applyStimulus($sformatf("rnd%0d", n), wr, addr, wd, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
